// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//
// Supervises an rPLL from its reference clock. The supervisor drives the PLL
// RESET input, brings the asynchronous LOCK output into the clkin domain and
// qualifies it over a stability window. Only then does it release the
// active-low system reset for the PLL-clocked logic. A lock attempt that times
// out is retried with a fresh PLL reset. After MAX_RETRIES failed attempts the
// supervisor parks in a terminal FAIL state with the PLL held in reset. A loss
// of lock while in service re-runs the whole acquisition.
//
// Optional build macro:
//   PLL_SUP_GLITCH_FILTER_EN  when defined, a loss of lock in service needs
//                             4 consecutive synchronized-low cycles. Shorter
//                             low pulses are ignored.
//
// Ports:
//   clkin        in   reference clock (same net as the PLL CLKIN)
//   rst_n        in   asynchronous active-low reset
//   pll_lock_i   in   PLL LOCK, asynchronous to clkin
//   pll_reset_o  out  PLL RESET, active high
//   sys_rst_n_o  out  active-low reset for downstream logic, high only in RUN
//   locked_o     out  qualified lock status, high only in RUN
//   fail_o       out  lock never achieved within MAX_RETRIES attempts
//   retry_cnt_o  out  failed attempts in the current acquisition
//   loss_cnt_o   out  in-service lock losses since rst_n, saturating at 255
//   state_dbg_o  out  current FSM state (state_t encoding), for debug/checkers
//
// All outputs are registered. Each control output is computed from the next
// state, so it changes on the same edge as the state it belongs to.

module pll_lock_supervisor #(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 27000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       clkin,
    input  logic       rst_n,
    input  logic       pll_lock_i,
    output logic       pll_reset_o,
    output logic       sys_rst_n_o,
    output logic       locked_o,
    output logic       fail_o,
    output logic [7:0] retry_cnt_o,
    output logic [7:0] loss_cnt_o,
    output logic [2:0] state_dbg_o
);

    typedef enum logic [2:0] {
        S_PLLRST    = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // One shared counter serves every state, so it must hold the largest
    // terminal value any state compares against. The floor of 4 also covers
    // the glitch-filter low-run count.
    localparam int unsigned CNT_MAX = max_u(max_u(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES),
                                            max_u(LOCK_STABLE_CYCLES, 4));
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    // The counter reaches LOCK_STABLE_CYCLES after that many lock-high
    // samples in S_STABLE. The release happens on the next high sample. With
    // the 2-cycle synchronizer this makes the release 2+N+1 edges after
    // LOCK is first sampled high.
    localparam logic [CNT_W-1:0] STABLE_DONE  = CNT_W'(LOCK_STABLE_CYCLES);
    localparam logic [7:0]       MAX_RETRY_V  = 8'(MAX_RETRIES);
`ifdef PLL_SUP_GLITCH_FILTER_EN
    localparam logic [CNT_W-1:0] GLITCH_LAST  = CNT_W'(3);
`endif

    logic             lock_meta;
    logic             lock_s;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [7:0]       retry_cnt;
    logic [7:0]       retry_nxt;
    logic [7:0]       loss_cnt;
    logic [7:0]       loss_nxt;
    logic             lock_lost;

    // Two-flop synchronizer for the asynchronous LOCK signal.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock_i;
            lock_s    <= lock_meta;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_PLLRST;
            cnt         <= '0;
            retry_cnt   <= '0;
            loss_cnt    <= '0;
            pll_reset_o <= 1'b1;
            sys_rst_n_o <= 1'b0;
            locked_o    <= 1'b0;
            fail_o      <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            retry_cnt   <= retry_nxt;
            loss_cnt    <= loss_nxt;
            pll_reset_o <= (state_nxt == S_PLLRST) || (state_nxt == S_FAIL);
            sys_rst_n_o <= (state_nxt == S_RUN);
            locked_o    <= (state_nxt == S_RUN);
            fail_o      <= (state_nxt == S_FAIL);
        end
    end

    // In-service loss detection.
`ifdef PLL_SUP_GLITCH_FILTER_EN
    // In S_RUN the counter tracks the current run of low samples.
    assign lock_lost = !lock_s && (cnt == GLITCH_LAST);
`else
    assign lock_lost = !lock_s;
`endif

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        retry_nxt = retry_cnt;
        loss_nxt  = loss_cnt;

        case (state)
            S_PLLRST: begin
                // LOCK is meaningless while the PLL is held in reset.
                if (cnt == RST_LAST) state_nxt = S_WAIT_LOCK;
            end

            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = S_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    retry_nxt = retry_cnt + 8'd1;
                    state_nxt = (retry_nxt == MAX_RETRY_V) ? S_FAIL : S_PLLRST;
                end
            end

            S_STABLE: begin
                if (!lock_s) begin
                    // Back to waiting. The entry clears cnt, so the timeout
                    // restarts. A dropout does not count as a failed attempt.
                    state_nxt = S_WAIT_LOCK;
                end else if (cnt == STABLE_DONE) begin
                    state_nxt = S_RUN;
                    retry_nxt = '0;
                end
            end

            S_RUN: begin
`ifdef PLL_SUP_GLITCH_FILTER_EN
                if (lock_s) cnt_nxt = '0;
`else
                cnt_nxt = '0;
`endif
                if (lock_lost) begin
                    loss_nxt  = (loss_cnt == 8'hFF) ? loss_cnt : loss_cnt + 8'd1;
                    state_nxt = S_PLLRST;
                end
            end

            S_FAIL: begin
                cnt_nxt = '0;
            end

            default: begin
                state_nxt = S_PLLRST;
            end
        endcase

        if (state_nxt != state) cnt_nxt = '0;
    end

    assign retry_cnt_o = retry_cnt;
    assign loss_cnt_o  = loss_cnt;
    assign state_dbg_o = state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Testbench for pll_lock_supervisor with small parameters.
// The bench drives the inputs on the falling edge and samples the outputs on
// the falling edge. A phase-level reference model in the bench predicts every
// output on every cycle. Directed sequences check reset, release latency,
// retries and FAIL, loss handling, saturation and asynchronous reset. A
// randomized phase follows at the end.

`timescale 1ns/1ps

module tb_pll_lock_supervisor;

  localparam int PLL_RST = 4;
  localparam int TIMEOUT = 50;
  localparam int STABLE  = 8;
  localparam int RETRIES = 2;
`ifdef PLL_SUP_GLITCH_FILTER_EN
  localparam int LOSS_LOW = 4;
`else
  localparam int LOSS_LOW = 1;
`endif

  // Phases of the acquisition, as described behaviourally.
  localparam int PH_PLLRST = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_STABLE = 2;
  localparam int PH_RUN    = 3;
  localparam int PH_FAIL   = 4;

  // ---------------- clock / reset / DUT ----------------
  logic       clkin = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock_i = 1'b0;
  logic       pll_reset_o;
  logic       sys_rst_n_o;
  logic       locked_o;
  logic       fail_o;
  logic [7:0] retry_cnt_o;
  logic [7:0] loss_cnt_o;
  logic [2:0] state_dbg_o;

  always #5 clkin = ~clkin;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES(PLL_RST),
    .LOCK_TIMEOUT_CYCLES(TIMEOUT),
    .LOCK_STABLE_CYCLES(STABLE),
    .MAX_RETRIES(RETRIES)
  ) dut (
    .clkin(clkin),
    .rst_n(rst_n),
    .pll_lock_i(pll_lock_i),
    .pll_reset_o(pll_reset_o),
    .sys_rst_n_o(sys_rst_n_o),
    .locked_o(locked_o),
    .fail_o(fail_o),
    .retry_cnt_o(retry_cnt_o),
    .loss_cnt_o(loss_cnt_o),
    .state_dbg_o(state_dbg_o)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int   m_phase, m_age, m_good, m_low, m_retry, m_loss;
  logic lock_hist[$];   // [0] = last sample, [1] = sample before that

  task automatic model_reset();
    m_phase = PH_PLLRST;
    m_age = 0; m_good = 0; m_low = 0; m_retry = 0; m_loss = 0;
    lock_hist = {};
    lock_hist.push_back(1'b0);
    lock_hist.push_back(1'b0);
  endtask

  task automatic enter(input int ph);
    m_phase = ph; m_age = 0; m_good = 0; m_low = 0;
  endtask

  // One clock edge. The control logic sees LOCK as it was sampled two edges
  // earlier.
  task automatic model_step(input logic lk);
    logic seen;
    seen = lock_hist[1];
    lock_hist.push_front(lk);
    while (lock_hist.size() > 2) void'(lock_hist.pop_back());
    m_age++;
    case (m_phase)
      PH_PLLRST: if (m_age == PLL_RST) enter(PH_WAIT);
      PH_WAIT: begin
        if (seen) enter(PH_STABLE);
        else if (m_age == TIMEOUT) begin
          m_retry++;
          if (m_retry == RETRIES) enter(PH_FAIL); else enter(PH_PLLRST);
        end
      end
      PH_STABLE: begin
        if (!seen) enter(PH_WAIT);
        else begin
          m_good++;
          if (m_good == STABLE + 1) begin m_retry = 0; enter(PH_RUN); end
        end
      end
      PH_RUN: begin
        m_low = seen ? 0 : m_low + 1;
        if (m_low == LOSS_LOW) begin
          if (m_loss < 255) m_loss++;
          enter(PH_PLLRST);
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    check("pll_reset_o", pll_reset_o, (m_phase == PH_PLLRST || m_phase == PH_FAIL));
    check("sys_rst_n_o", sys_rst_n_o, (m_phase == PH_RUN));
    check("locked_o",    locked_o,    (m_phase == PH_RUN));
    check("fail_o",      fail_o,      (m_phase == PH_FAIL));
    check("retry_cnt_o", retry_cnt_o, m_retry);
    check("loss_cnt_o",  loss_cnt_o,  m_loss);
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input logic lk);
    pll_lock_i = lk;
    @(posedge clkin);
    model_step(lk);
    @(negedge clkin);
    compare_all();
  endtask

  task automatic check_reset_values(input string where);
    check({where, "_pll_reset"}, pll_reset_o, 1);
    check({where, "_sys_rst_n"}, sys_rst_n_o, 0);
    check({where, "_locked"},    locked_o,    0);
    check({where, "_fail"},      fail_o,      0);
    check({where, "_retry"},     retry_cnt_o, 0);
    check({where, "_loss"},      loss_cnt_o,  0);
  endtask

  // Assert rst_n between clock edges and check that the outputs react before
  // any clock edge. Release it again at the next falling edge.
  task automatic async_reset_check(input string where);
    #2 rst_n = 1'b0;
    #1 check_reset_values(where);
    model_reset();
    @(negedge clkin);
    compare_all();
    rst_n = 1'b1;
  endtask

  // Hold LOCK high and count edges from the first high sample to the release.
  task automatic measure_release(input string tag);
    int lat;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      cycle(1'b1);
      if (sys_rst_n_o === 1'b1) begin lat = k - 1; break; end
    end
    check(tag, lat, 2 + STABLE + 1);
  endtask

  task automatic acquire(input string tag);
    for (int k = 0; k < 120 && locked_o !== 1'b1; k++) cycle(1'b1);
    check(tag, locked_o, 1);
  endtask

  // From RUN: drop LOCK long enough to count as a loss, then re-acquire.
  task automatic lose_and_reacquire();
    repeat (LOSS_LOW) cycle(1'b0);
    for (int k = 0; k < 10 && sys_rst_n_o === 1'b1; k++) cycle(1'b1);
    check("loss_drop", sys_rst_n_o, 0);
    check("reset_with_drop", pll_reset_o, 1);
    acquire("reacquire");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    repeat (2) @(negedge clkin);
    check_reset_values("por");
    rst_n = 1'b1;

    // PLL reset pulse length after release.
    for (int k = 1; k <= PLL_RST; k++) begin
      cycle(1'b0);
      check("pllrst_len", pll_reset_o, (k < PLL_RST));
    end

    // First acquisition: LOCK rises 10 cycles after PLL reset falls.
    repeat (10) cycle(1'b0);
    measure_release("release_latency");
    check("retry_after_lock", retry_cnt_o, 0);

`ifdef PLL_SUP_GLITCH_FILTER_EN
    // A short glitch is filtered.
    cycle(1'b0);
    repeat (6) cycle(1'b1);
    check("glitch_ignored_loss", loss_cnt_o, 0);
    check("glitch_ignored_lock", locked_o, 1);
`endif

    // Loss in service, then two more losses.
    lose_and_reacquire();
    check("loss_one", loss_cnt_o, 1);
    lose_and_reacquire();
    lose_and_reacquire();
    check("loss_three", loss_cnt_o, 3);
    repeat (3) cycle(1'b1);
    async_reset_check("rst_in_run");

    // A dropout during the stability window restarts qualification.
    repeat (PLL_RST + 3) cycle(1'b0);
    repeat (5) cycle(1'b1);
    repeat (3) cycle(1'b0);
    check("no_early_release", sys_rst_n_o, 0);
    measure_release("release_after_dropout");

    // Reset in the middle of the stability window.
    async_reset_check("rst_pre");
    repeat (PLL_RST) cycle(1'b0);
    repeat (5) cycle(1'b1);
    async_reset_check("rst_in_stable");
    repeat (PLL_RST) cycle(1'b1);

    // LOCK never arrives: two timeouts, then FAIL.
    async_reset_check("rst_pre_fail");
    repeat (PLL_RST + TIMEOUT - 1) cycle(1'b0);
    check("retry_before_timeout", retry_cnt_o, 0);
    cycle(1'b0);
    check("retry_first", retry_cnt_o, 1);
    check("pllrst_after_timeout", pll_reset_o, 1);
    repeat (PLL_RST + TIMEOUT) cycle(1'b0);
    check("retry_second", retry_cnt_o, 2);
    check("fail_set", fail_o, 1);
    repeat (30) cycle(1'b1);
    check("fail_sticky", fail_o, 1);
    check("fail_pll_held", pll_reset_o, 1);
    check("fail_no_sys", sys_rst_n_o, 0);

    // loss_cnt_o saturates at 255.
    async_reset_check("rst_pre_sat");
    acquire("sat_acquire");
    repeat (257) lose_and_reacquire();
    check("loss_saturate", loss_cnt_o, 255);

    // Randomized segments, with an occasional asynchronous reset.
    for (int seg = 0; seg < 160; seg++) begin
      logic val;
      int   len;
      if ($urandom_range(0, 29) == 0) async_reset_check("rand_rst");
      val = ($urandom_range(0, 3) != 0);
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(40, 120) : $urandom_range(1, 20);
      repeat (len) cycle(val);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
